// File: rtl/minitb_ahb_pipe_master.sv
// rtl/minitb_ahb_pipe_master.sv - pipelined AHB-Lite single-master engine with a command queue
//
// minitb_ahb_pipe_master_queue: small FIFO holding {write, addr, size, wdata}.
//   clk/rst_n      clock, async active-low reset
//   push/wdata     write one entry (caller guarantees not full)
//   pop/rdata      rdata is the head; pop removes it (caller guarantees not empty)
//   count          current occupancy
//
// minitb_ahb_pipe_master: issues queued commands as overlapped NONSEQ transfers.
//   hclk/hresetn   bus clock, async active-low reset
//   cmd_*          command queue input (cmd_ready = queue has space)
//   htrans/haddr/hwrite/hsize/hwdata   AHB-Lite master outputs, all registered
//   hrdata/hready/hresp                AHB-Lite slave response inputs
//   rsp_*          one registered pulse per completed transfer, in issue order

module minitb_ahb_pipe_master_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
endmodule

module minitb_ahb_pipe_master #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int cmdDepth  = 4
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [2:0]           cmd_size,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic [1:0]           htrans,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [dataWidth-1:0] hwdata,
    input  logic [dataWidth-1:0] hrdata,
    input  logic                 hready,
    input  logic                 hresp,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic                 rsp_err,
    output logic [dataWidth-1:0] rsp_rdata
);
    localparam int CMD_W = 1 + addrWidth + 3 + dataWidth;
    localparam int CW    = $clog2(cmdDepth) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(cmdDepth);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic {A_IDLE, A_BUSY} a_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ACTIVE, D_ERR} d_state_t;

    // Queue
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [CMD_W-1:0]     fifo_wdata;
    logic [CMD_W-1:0]     fifo_rdata;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;

    logic                 head_write;
    logic [addrWidth-1:0] head_addr;
    logic [2:0]           head_size;
    logic [dataWidth-1:0] head_wdata;

    // Address stage
    a_state_t             a_state_q;
    logic [1:0]           htrans_q;
    logic [addrWidth-1:0] haddr_q;
    logic                 hwrite_q;
    logic [2:0]           hsize_q;
    logic [dataWidth-1:0] a_wdata_q;

    // Data stage
    d_state_t             d_state_q;
    logic                 d_write_q;
    logic [dataWidth-1:0] hwdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_write_q;
    logic                 rsp_err_q;
    logic [dataWidth-1:0] rsp_rdata_q;

    // Control
    logic                 err_first;
    logic                 err_hold;
    logic                 accept;
    logic                 d_done;
    logic                 d_err;

    assign cmd_ready  = (fifo_count < DEPTH_CNT);
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_write, cmd_addr, cmd_size, cmd_wdata};
    assign fifo_empty = (fifo_count == '0);

    assign head_write = fifo_rdata[CMD_W-1];
    assign head_addr  = fifo_rdata[CMD_W-2 -: addrWidth];
    assign head_size  = fifo_rdata[dataWidth +: 3];
    assign head_wdata = fifo_rdata[dataWidth-1:0];

    minitb_ahb_pipe_master_queue #(
        .WIDTH (CMD_W),
        .DEPTH (cmdDepth)
    ) u_queue (
        .clk   (hclk),
        .rst_n (hresetn),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_comb begin
        // First cycle of the two-cycle ERROR response.
        err_first = (d_state_q == D_ACTIVE) && !hready && hresp;
        // Slave stretching the second ERROR cycle: keep the bus idle.
        err_hold  = (d_state_q == D_ERR) && !hready;
        accept    = (a_state_q == A_BUSY) && (htrans_q == TRANS_NONSEQ) && hready;
        d_done    = ((d_state_q == D_ACTIVE) || (d_state_q == D_ERR)) && hready;
        // hresp with hready outside D_ERR is a protocol violation, reported as an error.
        d_err     = d_done && ((d_state_q == D_ERR) || hresp);
        // Never start a new address phase during an ERROR response.
        fifo_pop  = !fifo_empty &&
                    (((a_state_q == A_IDLE) && !err_first && !err_hold) || accept);
    end

    // Address stage: owns htrans/haddr/hwrite/hsize and the pending wdata.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            a_state_q <= A_IDLE;
            htrans_q  <= TRANS_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            a_wdata_q <= '0;
        end else begin
            case (a_state_q)
                A_IDLE: begin
                    if (fifo_pop) begin
                        a_state_q <= A_BUSY;
                        htrans_q  <= TRANS_NONSEQ;
                        haddr_q   <= head_addr;
                        hwrite_q  <= head_write;
                        hsize_q   <= head_size;
                        a_wdata_q <= head_wdata;
                    end
                end
                A_BUSY: begin
                    if (htrans_q == TRANS_NONSEQ) begin
                        if (err_first) begin
                            // Cancel: keep the command, drop to IDLE for the error's second cycle.
                            htrans_q <= TRANS_IDLE;
                        end else if (accept) begin
                            if (fifo_pop) begin
                                haddr_q   <= head_addr;
                                hwrite_q  <= head_write;
                                hsize_q   <= head_size;
                                a_wdata_q <= head_wdata;
                            end else begin
                                a_state_q <= A_IDLE;
                                htrans_q  <= TRANS_IDLE;
                            end
                        end
                    end else if ((d_state_q == D_ERR) && hready) begin
                        // Re-issue the command cancelled by the ERROR response.
                        htrans_q <= TRANS_NONSEQ;
                    end
                end
                default: begin
                    a_state_q <= A_IDLE;
                    htrans_q  <= TRANS_IDLE;
                end
            endcase
        end
    end

    // Data stage: owns hwdata and the response outputs.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            d_state_q   <= D_IDLE;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= d_done;
            if (d_done) begin
                rsp_write_q <= d_write_q;
                rsp_err_q   <= d_err;
                rsp_rdata_q <= (!d_write_q && !d_err) ? hrdata : '0;
            end

            if (accept) begin
                d_write_q <= hwrite_q;
                if (hwrite_q) begin
                    hwdata_q <= a_wdata_q;
                end
            end

            case (d_state_q)
                D_IDLE: begin
                    if (accept) begin
                        d_state_q <= D_ACTIVE;
                    end
                end
                D_ACTIVE: begin
                    if (hready) begin
                        d_state_q <= accept ? D_ACTIVE : D_IDLE;
                    end else if (hresp) begin
                        d_state_q <= D_ERR;
                    end
                end
                D_ERR: begin
                    if (hready) begin
                        d_state_q <= D_IDLE;
                    end
                end
                default: begin
                    d_state_q <= D_IDLE;
                end
            endcase
        end
    end

    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_minitb_ahb_pipe_master.sv
// tb/tb_minitb_ahb_pipe_master.sv - scoreboard bench for minitb_ahb_pipe_master
module tb_minitb_ahb_pipe_master;
    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct packed {
        logic        w;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   n_rsp;

    minitb_ahb_pipe_master #(
        .addrWidth (8),
        .dataWidth (32),
        .cmdDepth  (4)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic rsp_t mk_rsp(input logic w, input logic e, input logic [31:0] d);
        rsp_t r;
        r.w = w;
        r.e = e;
        r.d = d;
        return r;
    endfunction

    task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = 3'd2;
        cmd_wdata = d;
    endtask

    // Response monitor: every pulse is popped against the scoreboard.
    always @(negedge hclk) begin : rsp_monitor
        rsp_t e;
        if (hresetn && rsp_valid) begin
            n_rsp++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp: got w=%0b e=%0b d=%h, required no response",
                         rsp_write, rsp_err, rsp_rdata);
            end else begin
                e = sb.pop_front();
                if ({rsp_write, rsp_err, rsp_rdata} !== {e.w, e.e, e.d}) begin
                    n_bad++;
                    $display("FAIL rsp_content: got w=%0b e=%0b d=%h, required w=%0b e=%0b d=%h",
                             rsp_write, rsp_err, rsp_rdata, e.w, e.e, e.d);
                end
            end
        end
    end

    task automatic test_reset;
        hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (2) @(negedge hclk);
        n_cmp++;
        if ({htrans, haddr, hwrite, hsize, hwdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h/%h/%b/%h/%h, required all zero", htrans, haddr, hwrite, hsize, hwdata);
        end
        n_cmp++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_rsp: got %b/%b/%b/%h, required all zero", rsp_valid, rsp_write, rsp_err, rsp_rdata);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
        end
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);
    endtask

    task automatic test_single_write;
        @(negedge hclk);
        drive_cmd(1'b1, 8'h10, 32'hDEADBEEF);
        hrdata = 32'hFFFFFFFF;
        sb.push_back(mk_rsp(1'b1, 1'b0, 32'h0));
        @(negedge hclk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (htrans !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_latency_idle: got htrans=%b, required 00", htrans);
        end
        @(negedge hclk);
        n_cmp++;
        if ({htrans, hwrite, haddr, hsize} !== {2'b10, 1'b1, 8'h10, 3'd2}) begin
            n_bad++;
            $display("FAIL wr_addr_phase: got %b/%b/%h/%h, required 10/1/10/2", htrans, hwrite, haddr, hsize);
        end
        @(negedge hclk);
        n_cmp++;
        if ({htrans, hwdata, rsp_valid} !== {2'b00, 32'hDEADBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL wr_data_phase: got %b/%h/%b, required 00/deadbeef/0", htrans, hwdata, rsp_valid);
        end
        @(negedge hclk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_rsp_timing: got rsp_valid=%b, required 1", rsp_valid);
        end
        @(negedge hclk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL wr_rsp_once: got rsp_valid=%b pending=%0d, required 0/0", rsp_valid, sb.size());
        end
    endtask

    task automatic test_wait_read;
        int r0;
        r0 = n_rsp;
        @(negedge hclk);
        drive_cmd(1'b0, 8'h20, 32'h0BADF00D);
        hrdata = 32'hBAD0BAD0;
        sb.push_back(mk_rsp(1'b0, 1'b0, 32'h12345678));
        @(negedge hclk);
        cmd_valid = 1'b0;
        @(negedge hclk);
        n_cmp++;
        if ({htrans, hwrite, haddr} !== {2'b10, 1'b0, 8'h20}) begin
            n_bad++;
            $display("FAIL rd_addr_phase: got %b/%b/%h, required 10/0/20", htrans, hwrite, haddr);
        end
        @(negedge hclk);
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({htrans, haddr, hwrite, hsize, hwdata, rsp_valid} !==
                {2'b00, 8'h20, 1'b0, 3'd2, 32'hDEADBEEF, 1'b0}) begin
                n_bad++;
                $display("FAIL rd_wait_hold[%0d]: got %b/%h/%b/%h/%h/%b, required 00/20/0/2/deadbeef/0",
                         k, htrans, haddr, hwrite, hsize, hwdata, rsp_valid);
            end
            if (k == 2) begin
                hready = 1'b1;
                hrdata = 32'h12345678;
            end
            @(negedge hclk);
        end
        hrdata = 32'hBAD0BAD0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_rsp_timing: got rsp_valid=%b, required 1", rsp_valid);
        end
        @(negedge hclk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || (n_rsp - r0) != 1) begin
            n_bad++;
            $display("FAIL rd_rsp_once: got rsp_valid=%b count=%0d, required 0/1", rsp_valid, n_rsp - r0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ad [4];
        logic        wr [4];
        logic [31:0] wd [4];
        logic [31:0] rd [4];
        int r0;
        ad[0] = 8'h00; wr[0] = 1'b1; wd[0] = 32'h11111111; rd[0] = 32'h0;
        ad[1] = 8'h04; wr[1] = 1'b0; wd[1] = 32'h0;        rd[1] = 32'h44444444;
        ad[2] = 8'h08; wr[2] = 1'b1; wd[2] = 32'h33333333; rd[2] = 32'h0;
        ad[3] = 8'h0C; wr[3] = 1'b0; wd[3] = 32'h0;        rd[3] = 32'hCCCCCCCC;
        r0 = n_rsp;
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            if (i >= 2 && i <= 5) begin
                n_cmp++;
                if ({htrans, haddr, hwrite} !== {2'b10, ad[i-2], wr[i-2]}) begin
                    n_bad++;
                    $display("FAIL b2b_addr[%0d]: got %b/%h/%b, required 10/%h/%b",
                             i - 2, htrans, haddr, hwrite, ad[i-2], wr[i-2]);
                end
            end
            if (i == 3 || i == 5) begin
                n_cmp++;
                if (hwdata !== wd[i-3]) begin
                    n_bad++;
                    $display("FAIL b2b_hwdata[%0d]: got %h, required %h", i - 3, hwdata, wd[i-3]);
                end
            end
            if (i >= 4) begin
                n_cmp++;
                if (rsp_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_rsp_consecutive[%0d]: got %b, required 1", i - 4, rsp_valid);
                end
            end
            if (i < 4) begin
                drive_cmd(wr[i], ad[i], wd[i]);
                sb.push_back(mk_rsp(wr[i], 1'b0, rd[i]));
            end else begin
                cmd_valid = 1'b0;
            end
            hrdata = (i == 4) ? 32'h44444444 : (i == 6) ? 32'hCCCCCCCC : 32'hBADBAD00;
        end
        @(negedge hclk);
        n_cmp++;
        if ({htrans, rsp_valid} !== {2'b00, 1'b0} || (n_rsp - r0) != 4) begin
            n_bad++;
            $display("FAIL b2b_end: got htrans=%b rsp_valid=%b count=%0d, required 00/0/4",
                     htrans, rsp_valid, n_rsp - r0);
        end
    endtask

    task automatic test_queue_full;
        int k;
        int cyc;
        int r0;
        logic w;
        r0 = n_rsp;
        k = 0;
        cyc = 0;
        hready = 1'b0;
        hrdata = 32'h600D0000;
        while (k < 6 && cyc < 100) begin
            @(negedge hclk);
            cyc++;
            if (cyc == 9) begin
                n_cmp++;
                if (k != 5 || cmd_ready !== 1'b0 || {htrans, haddr} !== {2'b10, 8'h80}) begin
                    n_bad++;
                    $display("FAIL full_backpressure: got accepted=%0d cmd_ready=%b htrans=%b haddr=%h, required 5/0/10/80",
                             k, cmd_ready, htrans, haddr);
                end
                hready = 1'b1;
            end
            w = (k % 2) == 0;
            drive_cmd(w, 8'h80 + 8'(4 * k), 32'hF0000000 + 32'(k));
            if (cmd_ready) begin
                sb.push_back(mk_rsp(w, 1'b0, w ? 32'h0 : 32'h600D0000));
                k++;
            end
        end
        @(negedge hclk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (k != 6) begin
            n_bad++;
            $display("FAIL full_push_timeout: got accepted=%0d, required 6", k);
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 60) begin
            @(negedge hclk);
            cyc++;
        end
        @(negedge hclk);
        n_cmp++;
        if (sb.size() != 0 || (n_rsp - r0) != 6) begin
            n_bad++;
            $display("FAIL full_drain: got pending=%0d count=%0d, required 0/6", sb.size(), n_rsp - r0);
        end
    endtask

    task automatic test_error;
        int r0;
        r0 = n_rsp;
        hready = 1'b1;
        hresp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge hclk);
            case (i)
                0: begin
                    drive_cmd(1'b1, 8'h40, 32'h40404040);
                    sb.push_back(mk_rsp(1'b1, 1'b1, 32'h0));
                end
                1: begin
                    drive_cmd(1'b0, 8'h44, 32'h0);
                    sb.push_back(mk_rsp(1'b0, 1'b0, 32'h44AA44AA));
                end
                2: cmd_valid = 1'b0;
                3: begin
                    n_cmp++;
                    if ({htrans, haddr, hwdata} !== {2'b10, 8'h44, 32'h40404040}) begin
                        n_bad++;
                        $display("FAIL err_pipeline: got %b/%h/%h, required 10/44/40404040", htrans, haddr, hwdata);
                    end
                    hready = 1'b0;
                    hresp = 1'b1;
                end
                4: begin
                    n_cmp++;
                    if ({htrans, haddr} !== {2'b00, 8'h44}) begin
                        n_bad++;
                        $display("FAIL err_cancel: got htrans=%b haddr=%h, required 00/44", htrans, haddr);
                    end
                    hready = 1'b1;
                end
                5: begin
                    n_cmp++;
                    if ({htrans, haddr, rsp_valid} !== {2'b10, 8'h44, 1'b1}) begin
                        n_bad++;
                        $display("FAIL err_redrive: got htrans=%b haddr=%h rsp_valid=%b, required 10/44/1",
                                 htrans, haddr, rsp_valid);
                    end
                    hresp = 1'b0;
                end
                6: begin
                    n_cmp++;
                    if (htrans !== 2'b00) begin
                        n_bad++;
                        $display("FAIL err_after_redrive: got htrans=%b, required 00", htrans);
                    end
                    hrdata = 32'h44AA44AA;
                end
                7: hrdata = 32'hBADBAD00;
                default: begin
                    n_cmp++;
                    if (rsp_valid !== 1'b0 || (n_rsp - r0) != 2) begin
                        n_bad++;
                        $display("FAIL err_rsp_count: got rsp_valid=%b count=%0d, required 0/2", rsp_valid, n_rsp - r0);
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_midop;
        int r0;
        logic stray;
        r0 = n_rsp;
        hready = 1'b1;
        hresp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            case (i)
                0: drive_cmd(1'b0, 8'hC0, 32'h0);
                1: drive_cmd(1'b1, 8'hC4, 32'hC4C4C4C4);
                2: drive_cmd(1'b1, 8'hC8, 32'hC8C8C8C8);
                3: begin
                    drive_cmd(1'b0, 8'hCC, 32'h0);
                    hready = 1'b0;
                end
                4: drive_cmd(1'b1, 8'hD0, 32'hD0D0D0D0);
                default: cmd_valid = 1'b0;
            endcase
        end
        n_cmp++;
        if ({htrans, haddr, cmd_ready} !== {2'b10, 8'hC4, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_setup: got htrans=%b haddr=%h cmd_ready=%b, required 10/c4/1", htrans, haddr, cmd_ready);
        end
        #2;
        hresetn = 1'b0;
        #1;
        n_cmp++;
        if ({htrans, haddr, hwrite, hsize, hwdata, rsp_valid, rsp_write, rsp_err, rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rst_async_outputs: got %b/%h/%b/%h/%h/%b/%b/%b/%h, required all zero",
                     htrans, haddr, hwrite, hsize, hwdata, rsp_valid, rsp_write, rsp_err, rsp_rdata);
        end
        @(negedge hclk);
        hready = 1'b1;
        hresetn = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            if (htrans !== 2'b00) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0 || cmd_ready !== 1'b1 || (n_rsp - r0) != 0) begin
            n_bad++;
            $display("FAIL rst_flush: got stray_nonseq=%b cmd_ready=%b count=%0d, required 0/1/0",
                     stray, cmd_ready, n_rsp - r0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_rsp = 0;
        test_reset();
        test_single_write();
        test_wait_read();
        test_back_to_back();
        test_queue_full();
        test_error();
        test_reset_midop();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/minitb_ahb_pipe_master.md
# minitb_ahb_pipe_master

Synthesizable, parametrised AHB-Lite single-master engine. It accepts read/write commands through a valid/ready queue and issues them as fully pipelined NONSEQ transfers, with the address phase of transfer N+1 overlapping the data phase of transfer N. It honours slave wait states and the two-cycle ERROR response, and returns one response per command. It sits between a test sequencer or DUT-side controller and an AHB-Lite slave, and replaces the task-driven master for pipelined and error-path work.

## Interface
- addrWidth, 8: haddr/cmd_addr width.
- dataWidth, 32: hwdata/hrdata width (8, 16, 32 or 64).
- cmdDepth, 4: command queue entries (≥2, power of 2).
- Clock and reset: one clock; reset is asynchronous and active-low.
- hclk  in  1  bus clock; all state on posedge.
- hresetn  in  1  async active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue has space (count < cmdDepth).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addrWidth  transfer address.
- cmd_size  in  3  HSIZE encoding; must be ≤ log2(dataWidth/8).
- cmd_wdata  in  dataWidth  write data (ignored for reads).
- htrans  out  2  IDLE=2'b00 / NONSEQ=2'b10 only.
- haddr  out  addrWidth
- hwrite  out  1
- hsize  out  3
- hwdata  out  dataWidth  valid during write data phase.
- hrdata  in  dataWidth
- hready  in  1
- hresp  in  1  0 = OKAY, 1 = ERROR.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_write  out  1  echo of the command type.
- rsp_err  out  1  transfer ended with ERROR.
- rsp_rdata  out  dataWidth  hrdata for reads; 0 for writes and errored reads.

## Operation
- Queue: FIFO of {write, addr, size, wdata}. A push occurs when cmd_valid && cmd_ready. cmd_ready is derived from the registered count, so there is no push when full even if a pop occurs in the same cycle.
- Address stage, states A_IDLE / A_BUSY:
  - A_IDLE → A_BUSY when the queue is non-empty: pop into the address register and drive NONSEQ.
  - In A_BUSY, the transfer is accepted at a posedge with hready=1. At that edge, pop the next command if available (stay A_BUSY), else go to A_IDLE (htrans=IDLE).
- Data stage, states D_IDLE / D_ACTIVE / D_ERR:
  - An accepted transfer enters D_ACTIVE. hwdata is driven from the accepted command's wdata for the whole data phase; on reads it holds its last value.
  - While hready=0 and hresp=0: hold all bus outputs.
  - hready=1 and hresp=0: complete with OKAY.
  - hready=0 and hresp=1 (first ERROR cycle): go to D_ERR. At the same edge, cancel the pending address phase: htrans=IDLE, and the command is kept in the address register (not lost, not re-popped).
  - In D_ERR with hready=1: complete with rsp_err=1. The cancelled command is re-driven as NONSEQ from that edge.
  - hresp=1 with hready=1 outside D_ERR is a protocol violation; the transfer is completed as an error.
- Responses are returned in issue order. There is no backpressure; the consumer must sample every pulse.
- When idle: haddr, hwrite and hsize hold their last values; htrans=IDLE.

## Timing
- All outputs are registered. cmd_ready is combinational from the count.
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_write=0, rsp_err=0, rsp_rdata=0, queue empty (cmd_ready=1), both stages idle.
- Latency:
  - Command pushed at edge E with the engine idle: NONSEQ is visible after edge E+1.
  - Zero-wait transfer: address accepted at edge E+2, data completes at edge E+3, rsp_valid is high for the cycle after E+3.
- Throughput: one transfer per cycle with zero wait states and a non-empty queue; htrans stays NONSEQ continuously.
- Each wait cycle adds exactly one cycle to both the data phase and the pending address phase.
- Reset mid-operation (hresetn low at any time): the queue is flushed, in-flight transfers are dropped with no response, and outputs take their reset values immediately.

## Test plan
- Single write 0x10 ← 0xDEADBEEF, zero wait: NONSEQ/hwrite=1/haddr=0x10 for one cycle, then hwdata=0xDEADBEEF. One rsp_valid with rsp_write=1, rsp_err=0, rsp_rdata=0; response after edge E+3.
- Single read 0x20 with 2 wait states, hrdata=0x12345678: hwdata and the bus outputs are held for 3 data cycles. rsp_rdata=0x12345678, and rsp_valid pulses exactly once.
- 4 back-to-back commands (W 0x00, R 0x04, W 0x08, R 0x0C), zero wait: NONSEQ for 4 consecutive cycles with addresses overlapping prior data phases. 4 responses in order on consecutive cycles.
- Queue-full backpressure (cmdDepth=4): hold hready=0 and push 6 commands. cmd_ready drops after 4 queued + 1 in address stage. All 6 eventually complete in order; none are duplicated or lost.
- ERROR on write 0x40 with read 0x44 pending: the cycle after the first ERROR cycle shows htrans=IDLE. 0x40 completes with rsp_err=1. 0x44 is re-driven as NONSEQ and completes OKAY; exactly 2 responses.
- hresetn asserted during a wait-stated read with 3 commands queued: all outputs go to reset values asynchronously, no rsp_valid is produced, and after release cmd_ready=1 with an empty queue.
